// File: rtl/pending_instr_tracker_pkg.sv
// Shared constants and fence state encoding for the pending-instruction tracker.
package pending_instr_tracker_pkg;
    localparam int DEF_NUM_WARPS   = 4;
    localparam int DEF_ISSUE_WIDTH = 2;
    localparam int NW_WIDTH        = (DEF_NUM_WARPS > 1) ? $clog2(DEF_NUM_WARPS) : 1;
    localparam int PENDING_CTR_W   = 6;

    typedef enum logic [1:0] {
        FENCE_IDLE = 2'd0,
        FENCE_WAIT = 2'd1,
        FENCE_DONE = 2'd2
    } fence_state_t;
endpackage

// File: rtl/pending_warp_ctr.sv
// One warp's in-flight counter: applies inc - dec each cycle with clamping to [0, max].
module pending_warp_ctr #(
    parameter int CTR_W = 6,
    parameter int DEC_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic [DEC_W-1:0] dec,
    output logic [CTR_W-1:0] ctr,
    output logic             pending,
    output logic             full,
    output logic             underflow,
    output logic             overflow
);
    // Two extra bits: one for the sign, one so max + 1 never wraps.
    localparam int SW = CTR_W + 2;
    localparam logic signed [SW-1:0] MAX_S = SW'((2 ** CTR_W) - 1);

    logic signed [SW-1:0] nxt;

    assign nxt       = $signed({2'b00, ctr}) + $signed(SW'(inc)) - $signed(SW'(dec));
    assign underflow = nxt < 0;
    assign overflow  = nxt > MAX_S;

    always_ff @(posedge clk) begin
        if (reset)          ctr <= '0;
        else if (underflow) ctr <= '0;
        else if (overflow)  ctr <= MAX_S[CTR_W-1:0];
        else                ctr <= nxt[CTR_W-1:0];
    end

    assign pending = ctr != '0;
    assign full    = &ctr;
endmodule

// File: rtl/pending_instr_tracker.sv
// Per-warp in-flight tracker: issue/commit decode, per-warp counters, drain fence and sticky error.
module pending_instr_tracker
    import pending_instr_tracker_pkg::*;
#(
    parameter int NUM_WARPS   = DEF_NUM_WARPS,
    parameter int ISSUE_WIDTH = DEF_ISSUE_WIDTH,
    parameter int CTR_W       = PENDING_CTR_W
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            issue_valid,
    input  logic [NW_WIDTH-1:0]             issue_wid,
    input  logic [ISSUE_WIDTH-1:0]          committed,
    input  logic [ISSUE_WIDTH*NW_WIDTH-1:0] committed_wid,
    output logic [NUM_WARPS-1:0]            pending,
    output logic [NUM_WARPS-1:0]            full,
    input  logic                            fence_valid,
    input  logic [NW_WIDTH-1:0]             fence_wid,
    output logic                            fence_ready,
    output logic                            err
);
    localparam int DEC_W = $clog2(ISSUE_WIDTH + 1);

    logic [NUM_WARPS-1:0]            inc;
    logic [NUM_WARPS-1:0]            underflow;
    logic [NUM_WARPS-1:0]            overflow;
    logic [NUM_WARPS-1:0][CTR_W-1:0] ctr;

    for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
        logic [DEC_W-1:0] hits;

        assign inc[w] = issue_valid && (issue_wid == NW_WIDTH'(w));

        // Several commit slots may retire the same warp in one cycle.
        always_comb begin
            hits = '0;
            for (int i = 0; i < ISSUE_WIDTH; i++) begin
                if (committed[i] && (committed_wid[i*NW_WIDTH +: NW_WIDTH] == NW_WIDTH'(w)))
                    hits = hits + DEC_W'(1);
            end
        end

        pending_warp_ctr #(.CTR_W(CTR_W), .DEC_W(DEC_W)) u_ctr (
            .clk       (clk),
            .reset     (reset),
            .inc       (inc[w]),
            .dec       (hits),
            .ctr       (ctr[w]),
            .pending   (pending[w]),
            .full      (full[w]),
            .underflow (underflow[w]),
            .overflow  (overflow[w])
        );
    end

    always_ff @(posedge clk) begin
        if (reset)                       err <= 1'b0;
        else if (|underflow || |overflow) err <= 1'b1;
    end

    fence_state_t          state, state_nxt;
    logic [NW_WIDTH-1:0]   fence_wid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FENCE_IDLE;
            fence_wid_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == FENCE_IDLE && fence_valid) fence_wid_q <= fence_wid;
        end
    end

    // An issue landing this cycle would make the drained warp busy again.
    always_comb begin
        state_nxt = state;
        case (state)
            FENCE_IDLE: if (fence_valid) state_nxt = FENCE_WAIT;
            FENCE_WAIT: begin
                if (!fence_valid)
                    state_nxt = FENCE_IDLE;
                else if (ctr[fence_wid_q] == '0 && !inc[fence_wid_q])
                    state_nxt = FENCE_DONE;
            end
            FENCE_DONE: state_nxt = FENCE_IDLE;
            default:    state_nxt = FENCE_IDLE;
        endcase
    end

    always_comb begin
        fence_ready = (state == FENCE_DONE);
    end
endmodule

// File: tb/tb_pending_instr_tracker.sv
// Scoreboard bench: directed test-plan cases followed by randomized traffic against a counter model.
module tb_pending_instr_tracker;
    localparam int NW    = 4;
    localparam int IW    = 2;
    localparam int CW    = 3;
    localparam int MAXC  = 7;

    logic       clk = 1'b0;
    logic       reset;
    logic       issue_valid;
    logic [1:0] issue_wid;
    logic [1:0] committed;
    logic [3:0] committed_wid;
    logic [3:0] pending, full;
    logic       fence_valid;
    logic [1:0] fence_wid;
    logic       fence_ready;
    logic       err;

    pending_instr_tracker #(.NUM_WARPS(NW), .ISSUE_WIDTH(IW), .CTR_W(CW)) dut (
        .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_wid(issue_wid),
        .committed(committed), .committed_wid(committed_wid), .pending(pending), .full(full),
        .fence_valid(fence_valid), .fence_wid(fence_wid), .fence_ready(fence_ready), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] pending;
        logic [3:0] full;
        logic       ready;
        logic       err;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference state: plain counters, sticky error, and fence progress.
    int m_ctr[NW];
    bit m_err;
    bit m_fence_req;    // a fence request has been latched
    bit m_fence_ready;  // fence satisfied, ready is showing
    int m_fwid;

    task automatic step(input bit rst, input bit iv, input int iw,
                        input bit c0, input int w0, input bit c1, input int w1,
                        input bit fv, input int fw);
        exp_t e;
        @(negedge clk);
        reset         = rst;
        issue_valid   = iv;
        issue_wid     = 2'(iw);
        committed     = {c1, c0};
        committed_wid = {2'(w1), 2'(w0)};
        fence_valid   = fv;
        fence_wid     = 2'(fw);
        cyc++;
        if (rst) begin
            foreach (m_ctr[w]) m_ctr[w] = 0;
            m_err = 0; m_fence_req = 0; m_fence_ready = 0;
        end else begin
            // Fence progress looks at the counters as they stand before this edge.
            if (m_fence_ready) begin
                m_fence_ready = 0;
            end else if (m_fence_req) begin
                if (!fv) m_fence_req = 0;
                else if (m_ctr[m_fwid] == 0 && !(iv && iw == m_fwid)) begin
                    m_fence_req = 0; m_fence_ready = 1;
                end
            end else if (fv) begin
                m_fence_req = 1; m_fwid = fw;
            end
            for (int w = 0; w < NW; w++) begin
                int n;
                n = m_ctr[w] + int'(iv && iw == w) - int'(c0 && w0 == w) - int'(c1 && w1 == w);
                if (n < 0)    begin n = 0;    m_err = 1; end
                if (n > MAXC) begin n = MAXC; m_err = 1; end
                m_ctr[w] = n;
            end
        end
        for (int w = 0; w < NW; w++) begin
            e.pending[w] = m_ctr[w] != 0;
            e.full[w]    = m_ctr[w] == MAXC;
        end
        e.ready = m_fence_ready;
        e.err   = m_err;
        e.cyc   = cyc;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: outputs are registered, so each cycle presents one expected snapshot.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (pending !== e.pending || full !== e.full || fence_ready !== e.ready || err !== e.err) begin
                    errors++;
                    $display("FAIL outputs cyc %0d: got pending=%b full=%b ready=%b err=%b exp pending=%b full=%b ready=%b err=%b",
                             e.cyc, pending, full, fence_ready, err, e.pending, e.full, e.ready, e.err);
                end
            end
        end
    end

    initial begin
        bit fv, fired, ready_now, drain;
        int fw;
        reset = 1; issue_valid = 0; issue_wid = 0; committed = 0; committed_wid = 0;
        fence_valid = 0; fence_wid = 0;

        do_reset();
        // Three issues to warp 2, then a double commit leaves one pending.
        for (int k = 0; k < 3; k++) step(0, 1, 2, 0, 0, 0, 0, 0, 0);
        idle(2);
        step(0, 0, 0, 1, 2, 1, 2, 0, 0);
        idle(2);
        step(0, 0, 0, 1, 2, 0, 0, 0, 0);
        idle(1);

        // Issue and commit together on warp 1 at count 4.
        for (int k = 0; k < 4; k++) step(0, 1, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 1, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 1, 1, 0, 0);
        idle(1);

        // Fill warp 0 to max, then overflow.
        do_reset();
        for (int k = 0; k < MAXC; k++) step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // Underflow on an empty warp; error stays until reset.
        do_reset();
        step(0, 0, 0, 0, 0, 1, 3, 0, 0);
        idle(3);
        do_reset();

        // Fence on warp 0 with two pending, commits at t4 and t6.
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int t = 0; t <= 8; t++)
            step(0, 0, 0, t == 4 || t == 6, 0, 0, 0, 1, 0);
        idle(2);

        // Fence on an idle warp completes two cycles after the request.
        for (int t = 0; t <= 2; t++) step(0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(2);

        // Reset in the middle of a fence wait.
        step(0, 1, 2, 0, 0, 0, 0, 0, 0);
        step(0, 1, 3, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 2);
        step(0, 0, 0, 0, 0, 0, 0, 1, 2);
        step(1, 0, 0, 0, 0, 0, 0, 1, 2);
        idle(3);

        // Randomized traffic with alternating fill/drain pressure.
        fv = 0; fw = 0; fired = 0; drain = 0;
        for (int n = 0; n < 4000; n++) begin
            bit rst, iv, c0, c1;
            int iw, w0, w1;
            if (n % 40 == 0) drain = ~drain;
            rst = (n % 500 == 499);
            iv  = $urandom_range(99) < (drain ? 30 : 65);
            iw  = $urandom_range(NW - 1);
            if (m_ctr[iw] == MAXC && $urandom_range(9) != 0) iv = 0;
            c0 = $urandom_range(99) < (drain ? 60 : 20);
            c1 = $urandom_range(99) < (drain ? 45 : 10);
            w0 = $urandom_range(NW - 1);
            w1 = $urandom_range(NW - 1);
            if (m_ctr[w0] == 0 && $urandom_range(7) != 0) c0 = 0;
            if (m_ctr[w1] == 0 && $urandom_range(7) != 0) c1 = 0;
            if (fired) fv = 0;
            else if (!fv) begin
                if ($urandom_range(9) == 0) begin fv = 1; fw = $urandom_range(NW - 1); end
            end else if ($urandom_range(59) == 0) fv = 0;
            ready_now = m_fence_ready;
            step(rst, iv, iw, c0, w0, c1, w1, fv, fw);
            fired = fv && ready_now && !rst;
        end
        idle(2);

        // Let the monitor drain its queue within a bounded number of cycles.
        for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: got %0d left exp 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pending_instr_tracker.md
# pending_instr_tracker

Per-warp in-flight instruction tracker between the issue scheduler and the commit stage. It increments a warp's counter when the scheduler issues an instruction and decrements it on each end-of-packet commit reported by the commit stage's registered `committed`/`committed_wid` outputs. It exports per-warp pending and full flags to the scheduler, and serves a single fence request that completes once a chosen warp has fully drained.

## Interface
Parameters:
- `NUM_WARPS`, default `NUM_WARPS`: number of warps tracked.
- `ISSUE_WIDTH`, default `ISSUE_WIDTH`: number of commit slots per cycle.
- `CTR_W`, default 6: counter width; maximum pending per warp is 2^CTR_W-1.

Ports:
- `clk`, in, 1: single clock.
- `reset`, in, 1: reset is synchronous and active-high.
- `issue_valid`, in, 1: one instruction issued this cycle.
- `issue_wid`, in, `NW_WIDTH`: warp of the issued instruction.
- `committed`, in, `ISSUE_WIDTH`: per-slot final commit pulse.
- `committed_wid`, in, `ISSUE_WIDTH*NW_WIDTH`: per-slot warp id.
- `pending`, out, `NUM_WARPS`: the warp's counter is not zero.
- `full`, out, `NUM_WARPS`: the warp's counter is at its maximum; the scheduler must not issue to that warp.
- `fence_valid`, in, 1: fence request; held high until accepted.
- `fence_wid`, in, `NW_WIDTH`: warp to drain; stable while `fence_valid` is high.
- `fence_ready`, out, 1: fence completes on `fence_valid && fence_ready`.
- `err`, out, 1: sticky flag for underflow or overflow.

## Operation
- **Per-warp counter update.** Each cycle, every warp computes `delta = inc - dec`.
  - `inc = issue_valid && issue_wid==w`.
  - `dec` = number of slots i with `committed[i] && committed_wid[i]==w`.
  - `dec` ranges 0..ISSUE_WIDTH, and several slots may hit the same warp in one cycle.
  - Arithmetic uses CTR_W+2 signed bits, then the result is clamped to [0, max].
- **Simultaneous issue and commit** to the same warp: net change is 0, and no flag toggles.
- **Underflow** (result < 0): counter is set to 0 and `err` is set.
- **Overflow** (issue while full, result > max): counter holds at max and `err` is set.
- **Flag derivation.** `pending[w] = ctr[w]!=0` and `full[w] = ctr[w]==max`. Both are driven from the registered counters only.
- **Fence FSM**, 3 states:
  - IDLE: on `fence_valid`, latch `fence_wid` and go to WAIT.
  - WAIT: if `fence_valid` drops, go to IDLE (abort). If `ctr[wid]==0` and there is no `inc` for `wid` this cycle, go to DONE.
  - DONE: `fence_ready=1`. On fire, go to IDLE. If `fence_valid` drops, go to IDLE.
- Issue to the fenced warp during DONE is legal. The fence has already been satisfied.

## Timing
- **Reset.** All counters 0, `pending`=0, `full`=0, `fence_ready`=0, `err`=0, FSM in IDLE.
- **Reset mid-fence.** Returns to IDLE with no `fence_ready` pulse.
- **Counter update latency.** Inputs at the edge of cycle t are visible in `pending`/`full` at t+1. There are no combinational input-to-output paths.
- **Minimum fence latency.** `fence_valid` at t with the warp already drained gives `fence_ready` high at t+2: IDLE to WAIT at t+1, WAIT to DONE at t+2.
- **`fence_ready` duration.** Remains high until fire or abort, one cycle minimum.
- **`err`.** Sets at the edge after the offending cycle and clears only on reset.

## Structure
- Shared package holds:
  - `NW_WIDTH`.
  - The fence state enum (`FENCE_IDLE`, `FENCE_WAIT`, `FENCE_DONE`).
  - The `PENDING_CTR_W` default constant.
- Sub-module `pending_warp_ctr`, one instance per warp. It takes the inc and dec inputs and produces the counter, `pending`, `full`, and the underflow/overflow pulses.
- The top level holds the per-warp decode of issue/commit, the popcount of per-slot matches, the fence FSM, and `err` OR-reduction.

## Test plan
- Issue warp 2 three times (t0..t2), then commit warp 2 in slots 0 and 1 at t5 with ISSUE_WIDTH=2 → counter 1 at t6, and `pending[2]` stays 1 until a further commit.
- Issue warp 1 and commit warp 1 in the same cycle with counter=4 → counter stays 4, and neither `pending` nor `full` toggles.
- With CTR_W=2, issue warp 0 three times → `full[0]`=1. A fourth issue → counter 3 and `err`=1 from the next cycle.
- Commit warp 3 while its counter is 0 → counter stays 0 and `err`=1. `err` stays set until reset.
- Fence on warp 0 with counter 2, commits at t4 and t6 → `fence_ready` rises at t8 and the fire returns the FSM to IDLE. A separate fence on an idle warp at t0 → `fence_ready` at t2.
- Assert reset while in WAIT with counters nonzero → the next cycle shows all outputs 0 and FSM in IDLE.
